serial_add_seq: RTL and testbench

//  Bit-serial adder sequencer. Accepts two W-bit operands and a carry-in, then time-shares
//  one full_adder instance across all bit positions, LSB first, one bit per clock.

---
 rtl/serial_add_seq_if.sv | 31 +++
 rtl/serial_add_seq.sv | 131 +++++++++++++
 tb/tb_serial_add_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_seq_if.sv
// ============================================================================
// Module  : serial_add_seq_if
// Brief   : Start/done request bus between a requester and serial_add_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_add_seq_if #(
  parameter int W = 8
) ();
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_carry;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_carry;

  modport master (
    output i_start, i_a, i_b, i_carry,
    input  o_busy, o_done, o_sum, o_carry
  );

  modport slave (
    input  i_start, i_a, i_b, i_carry,
    output o_busy, o_done, o_sum, o_carry
  );
endinterface

`default_nettype wire

// File: rtl/serial_add_seq.sv
// ============================================================================
// Module  : serial_add_seq (+ full_adder)
// Brief   : Bit-serial adder, one shared full adder, LSB first, one bit/clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  wire logic i_x,
  input  wire logic i_y,
  input  wire logic i_carry,
  output logic      o_sum,
  output logic      o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_carry;
  assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));
endmodule

module serial_add_seq #(
  parameter int W = 8
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  serial_add_seq_if.slave  bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  psum_q, psum_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cy_q, cy_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          w_fa_sum;
  logic          w_fa_carry;
  logic [W-1:0]  w_psum_next;

  full_adder u_fa (
    .i_x     (a_q[0]),
    .i_y     (b_q[0]),
    .i_carry (cy_q),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  // New sum bit enters at the MSB so the word is LSB-aligned after W steps.
  generate
    if (W == 1) begin : g_psum_w1
      assign w_psum_next = w_fa_sum;
    end else begin : g_psum_wn
      assign w_psum_next = {w_fa_sum, psum_q[W-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_RUN;
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          cy_d    = bus.i_carry;
          cnt_d   = '0;
          psum_d  = '0;
        end
      end
      S_RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        psum_d = w_psum_next;
        cy_d   = w_fa_carry;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          cnt_d   = cnt_q;
          sum_d   = w_psum_next;
          cout_d  = w_fa_carry;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_busy  = (state_q != S_IDLE);
  assign bus.o_done  = (state_q == S_DONE);
  assign bus.o_sum   = sum_q;
  assign bus.o_carry = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_serial_add_seq.sv
// ============================================================================
// Module  : tb_serial_add_seq
// Brief   : Directed, table-driven checks of serial_add_seq at W=8 and W=1.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_seq;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_add_seq_if #(.W(8)) b8 ();
  serial_add_seq_if #(.W(1)) b1 ();

  serial_add_seq #(.W(8)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
  serial_add_seq #(.W(1)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one W=8 operation; lat = edges from accept to o_done (-1 on timeout).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output logic [7:0] s, output logic co, output int lat,
                      output int busy_cnt);
    @(negedge clk);
    b8.i_start = 1'b1; b8.i_a = a; b8.i_b = b; b8.i_carry = c;
    @(negedge clk);
    b8.i_start = 1'b0; b8.i_a = ~a; b8.i_b = ~b; b8.i_carry = ~c;
    lat = -1;
    busy_cnt = b8.o_busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b8.o_busy) busy_cnt++;
      if (b8.o_done) begin
        lat = k;
        break;
      end
    end
    s  = b8.o_sum;
    co = b8.o_carry;
    @(negedge clk);
    if (b8.o_busy) busy_cnt++;
  endtask

  logic [7:0] s;
  logic       co;
  int         lat;
  int         bcnt;
  int         ndone;
  logic       stable;
  logic [7:0] first_sum;
  logic       first_co;
  logic [1:0] exp1 [8];

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    exp1 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    // Reset held for two edges with start asserted
    rst_n = 1'b0;
    b8.i_start = 1'b1; b8.i_a = 8'h3C; b8.i_b = 8'h05; b8.i_carry = 1'b1;
    b1.i_start = 1'b1; b1.i_a = 1'b1;  b1.i_b = 1'b1;  b1.i_carry = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(b8.o_busy),  32'd0);
    check("rst_done",  32'(b8.o_done),  32'd0);
    check("rst_sum",   32'(b8.o_sum),   32'd0);
    check("rst_carry", 32'(b8.o_carry), 32'd0);
    check("rst_busy_w1", 32'(b1.o_busy), 32'd0);
    b8.i_start = 1'b0;
    b1.i_start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bcnt);
      check($sformatf("v%0d_sum", i),   32'(s),  32'(vecs[i].sum));
      check($sformatf("v%0d_carry", i), 32'(co), 32'(vecs[i].cout));
      check($sformatf("v%0d_lat", i),   32'(lat), 32'd8);
      check($sformatf("v%0d_busy", i),  32'(bcnt), 32'd9);
    end

    // Start pulsed mid-RUN is ignored; result held until the single done
    @(negedge clk);
    b8.i_start = 1'b1; b8.i_a = 8'h3C; b8.i_b = 8'h05; b8.i_carry = 1'b0;
    @(negedge clk);
    b8.i_start = 1'b0;
    ndone = 0; stable = 1'b1; first_sum = 8'hEE; first_co = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) begin
        b8.i_start = 1'b1; b8.i_a = 8'h11; b8.i_b = 8'h22; b8.i_carry = 1'b1;
      end else begin
        b8.i_start = 1'b0;
      end
      if (ndone == 0 && !b8.o_done && (b8.o_sum !== 8'h00 || b8.o_carry !== 1'b1))
        stable = 1'b0;
      if (b8.o_done) begin
        if (ndone == 0) begin
          first_sum = b8.o_sum;
          first_co  = b8.o_carry;
        end
        ndone++;
      end
    end
    check("ign_ndone",  32'(ndone),     32'd1);
    check("ign_stable", 32'(stable),    32'd1);
    check("ign_sum",    32'(first_sum), 32'h41);
    check("ign_carry",  32'(first_co),  32'd0);

    // Reset during RUN cycle 4 aborts without done and clears the result
    @(negedge clk);
    b8.i_start = 1'b1; b8.i_a = 8'hAA; b8.i_b = 8'h55; b8.i_carry = 1'b0;
    @(negedge clk);
    b8.i_start = 1'b0;
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (b8.o_done) ndone++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(b8.o_busy),  32'd0);
    check("abort_sum",   32'(b8.o_sum),   32'd0);
    check("abort_carry", 32'(b8.o_carry), 32'd0);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (b8.o_done) ndone++;
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    run8(8'h01, 8'h01, 1'b0, s, co, lat, bcnt);
    check("post_abort_sum", 32'(s),   32'h02);
    check("post_abort_lat", 32'(lat), 32'd8);

    // W=1: full-adder truth table, single RUN cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b1.i_start = 1'b1;
      b1.i_a = i[2]; b1.i_b = i[1]; b1.i_carry = i[0];
      @(negedge clk);
      b1.i_start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (b1.o_done) begin
          lat = k;
          break;
        end
      end
      check($sformatf("w1_%0d_res", i), 32'({b1.o_carry, b1.o_sum}), 32'(exp1[i]));
      check($sformatf("w1_%0d_lat", i), 32'(lat), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
